// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and the
// constant function that sizes the bit counter.
package serial_subtractor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Smallest r with 2**r >= n; usable in constant expressions.
  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B, one bit per clock, LSB first, with a
// registered borrow; start/busy/done handshake and parallel operands/result.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned      CNT_W = clog2_f(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bor_q, bor_d;
  logic             done_q, done_d;

  logic             fs_d, fs_bo;
  logic [WIDTH-1:0] shifted;

  full_subtractor u_cell (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .bin (br_q),
    .d   (fs_d),
    .bout(fs_bo)
  );

  // Result bits already produced sit below the new bit; the LSB of this
  // concatenation is dropped each cycle until the final edge uses all of it.
  assign shifted = {fs_d, res_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bor_d   = bor_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = shifted[WIDTH-1:1];
        br_d  = fs_bo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          diff_d  = shifted;
          bor_d   = fs_bo;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bor_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bor_q   <= bor_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bor_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16 against a
// cycle-level behavioural model, plus the full_subtractor cell exhaustively.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_v [2];
  logic [31:0] a_v     [2];
  logic [31:0] b_v     [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic        bor_o   [2];
  logic [31:0] diff_o  [2];

  logic [7:0]  diff8;
  logic [15:0] diff16;
  logic        busy8, done8, bor8, busy16, done16, bor16;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bor8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .a(a_v[1][15:0]), .b(b_v[1][15:0]),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bor16)
  );

  always_comb begin
    busy_o[0] = busy8;  done_o[0] = done8;  bor_o[0] = bor8;  diff_o[0] = {24'd0, diff8};
    busy_o[1] = busy16; done_o[1] = done16; bor_o[1] = bor16; diff_o[1] = {16'd0, diff16};
  end

  logic fx, fy, fb, fd, fbo;
  full_subtractor u_fs (.x(fx), .y(fy), .bin(fb), .d(fd), .bout(fbo));

  function automatic int wof(input int k);
    return (k == 0) ? 8 : 16;
  endfunction

  function automatic logic [31:0] mask(input int k);
    return (k == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
  endfunction

  // Behavioural model: an accepted request completes WIDTH edges later with
  // (a-b) mod 2^WIDTH and (a<b); outputs hold between completions.
  logic        m_busy [2];
  logic        m_done [2];
  int          m_left [2];
  logic [31:0] m_pend [2];
  logic        m_pbor [2];
  logic [31:0] m_diff [2];
  logic        m_bor  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_left[k] <= 0;
        m_pend[k] <= '0;   m_pbor[k] <= 1'b0; m_diff[k] <= '0; m_bor[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_done[k] <= 1'b0;
        if (m_busy[k]) begin
          m_left[k] <= m_left[k] - 1;
          if (m_left[k] == 1) begin
            m_busy[k] <= 1'b0;
            m_done[k] <= 1'b1;
            m_diff[k] <= m_pend[k];
            m_bor[k]  <= m_pbor[k];
          end
        end else if (start_v[k]) begin
          m_busy[k] <= 1'b1;
          m_left[k] <= wof(k);
          m_pend[k] <= (a_v[k] - b_v[k]) & mask(k);
          m_pbor[k] <= (a_v[k] < b_v[k]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy[w%0d]", wof(k)), 32'(busy_o[k]), 32'(m_busy[k]));
        chk($sformatf("done[w%0d]", wof(k)), 32'(done_o[k]), 32'(m_done[k]));
        chk($sformatf("diff[w%0d]", wof(k)), diff_o[k], m_diff[k]);
        chk($sformatf("borrow[w%0d]", wof(k)), 32'(bor_o[k]), 32'(m_bor[k]));
      end
    end
  end

  task automatic drive(input int k, input logic s, input logic [31:0] av, input logic [31:0] bv);
    start_v[k] = s;
    a_v[k]     = av & mask(k);
    b_v[k]     = bv & mask(k);
  endtask

  // Issue one request and wait (bounded) for its done; checks latency and
  // the literal result. Optionally scrambles start/a/b while running.
  task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                        input bit scramble, input logic [31:0] ed, input logic eb);
    int  t0;
    bit  seen;
    drive(k, 1'b1, av, bv);
    @(posedge clk); #2;
    t0 = cyc;
    if (scramble) drive(k, 1'($urandom_range(0, 1)), $urandom, $urandom);
    else          drive(k, 1'b0, av, bv);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (done_o[k]) seen = 1'b1;
      else if (scramble) drive(k, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    drive(k, 1'b0, av, bv);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout[w%0d]: no done within 40 cycles, expected one", wof(k));
    end else begin
      chk("latency", 32'(cyc - t0), 32'(wof(k)));
      chk("op_diff", diff_o[k], ed);
      chk("op_borrow", 32'(bor_o[k]), 32'(eb));
    end
  endtask

  task automatic wait_done(input int k, output int when, output bit ok);
    ok = 1'b0;
    when = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (done_o[k]) begin ok = 1'b1; when = cyc; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout: no done within 40 cycles, expected one");
    end
  endtask

  initial begin
    int t1, t2;
    bit ok1, ok2;
    logic [31:0] ra, rb;

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 0, 0);
    fx = 0; fy = 0; fb = 0;
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", 32'(busy_o[k]), 0);
      chk("rst_done", 32'(done_o[k]), 0);
      chk("rst_diff", diff_o[k], 0);
      chk("rst_borrow", 32'(bor_o[k]), 0);
    end

    for (int i = 0; i < 8; i++) begin
      int r;
      {fx, fy, fb} = 3'(i);
      #1;
      r = int'(fx) - int'(fy) - int'(fb);
      chk($sformatf("fs_d[%0d]", i), 32'(fd), 32'(r & 1));
      chk($sformatf("fs_bout[%0d]", i), 32'(fbo), 32'(r < 0));
    end
    fx = 0; fy = 1; fb = 0; #1;
    chk("fs_010", {30'd0, fd, fbo}, 32'b11);
    fx = 1; fy = 1; fb = 1; #1;
    chk("fs_111", {30'd0, fd, fbo}, 32'b11);

    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_op(0, 5, 3, 1'b0, 32'h02, 1'b0);
    run_op(0, 3, 5, 1'b0, 32'hFE, 1'b1);
    run_op(0, 8'h00, 8'h00, 1'b0, 32'h00, 1'b0);
    run_op(0, 8'h00, 8'h01, 1'b0, 32'hFF, 1'b1);
    run_op(0, 8'hFF, 8'hFF, 1'b0, 32'h00, 1'b0);
    run_op(1, 16'h1234, 16'h1235, 1'b0, 32'hFFFF, 1'b1);

    // start held high across two operations
    drive(0, 1'b1, 9, 4);
    @(posedge clk); #2;
    drive(0, 1'b1, 4, 9);
    wait_done(0, t1, ok1);
    if (ok1) begin
      chk("b2b_diff1", diff_o[0], 32'h05);
      chk("b2b_bor1", 32'(bor_o[0]), 0);
    end
    @(posedge clk); #2;
    drive(0, 1'b0, 4, 9);
    wait_done(0, t2, ok2);
    if (ok1 && ok2) begin
      chk("b2b_gap", 32'(t2 - t1), 32'(wof(0) + 1));
      chk("b2b_diff2", diff_o[0], 32'hFB);
      chk("b2b_bor2", 32'(bor_o[0]), 1);
    end

    run_op(0, 8'hA0, 8'h21, 1'b1, 32'h7F, 1'b0);
    run_op(1, 16'h0100, 16'h0200, 1'b1, 32'hFF00, 1'b1);

    // asynchronous reset in the middle of 5-3
    drive(0, 1'b1, 5, 3);
    @(posedge clk); #2;
    drive(0, 1'b0, 5, 3);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("amid_busy", 32'(busy_o[0]), 0);
    chk("amid_done", 32'(done_o[0]), 0);
    chk("amid_diff", diff_o[0], 0);
    chk("amid_borrow", 32'(bor_o[0]), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < wof(0) + 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_done", 32'(done_o[0]), 0);
    end
    run_op(0, 7, 2, 1'b0, 32'h05, 1'b0);

    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < 2; k++) begin
        ra = $urandom & mask(k);
        rb = $urandom & mask(k);
        if (i % 10 == 0) rb = ra;
        if (i % 17 == 0) ra = mask(k);
        run_op(k, ra, rb, ($urandom_range(0, 3) == 0),
               (ra - rb) & mask(k), (ra < rb));
      end
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
